des_sbox_engine: RTL

Parametrised DES substitution engine: accepts one 48-bit expanded-and-keyed round word, applies the eight DES S-boxes S1..S8 and returns the 32-bit substituted word. It sits between the round-key XOR and the P-permutation in the round datapath. It replaces per-box combinational lookups with a shared, lane-configurable unit: LANES S-boxes are evaluated per cycle, and valid/ready handshakes sit on both sides.

---
 rtl/des_sbox_pkg.sv | 65 ++++++
 rtl/des_sbox_lane.sv | 15 +
 rtl/des_sbox_engine.sv | 105 ++++++++++
 3 files changed

// File: rtl/des_sbox_pkg.sv
// des_sbox_pkg: shared definitions for the DES substitution engine.
//   state_t      - engine FSM states
//   SBOX         - the eight DES S-box tables, indexed [box][row][col]
//   sbox_lookup  - (box 0..7 = S1..S8, 6-bit field) -> 4-bit substitution
package des_sbox_pkg;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam logic [3:0] SBOX [8][4][16] = '{
    '{ // S1
      '{4'd14, 4'd4,  4'd13, 4'd1,  4'd2,  4'd15, 4'd11, 4'd8,  4'd3,  4'd10, 4'd6,  4'd12, 4'd5,  4'd9,  4'd0,  4'd7 },
      '{4'd0,  4'd15, 4'd7,  4'd4,  4'd14, 4'd2,  4'd13, 4'd1,  4'd10, 4'd6,  4'd12, 4'd11, 4'd9,  4'd5,  4'd3,  4'd8 },
      '{4'd4,  4'd1,  4'd14, 4'd8,  4'd13, 4'd6,  4'd2,  4'd11, 4'd15, 4'd12, 4'd9,  4'd7,  4'd3,  4'd10, 4'd5,  4'd0 },
      '{4'd15, 4'd12, 4'd8,  4'd2,  4'd4,  4'd9,  4'd1,  4'd7,  4'd5,  4'd11, 4'd3,  4'd14, 4'd10, 4'd0,  4'd6,  4'd13}
    },
    '{ // S2
      '{4'd15, 4'd1,  4'd8,  4'd14, 4'd6,  4'd11, 4'd3,  4'd4,  4'd9,  4'd7,  4'd2,  4'd13, 4'd12, 4'd0,  4'd5,  4'd10},
      '{4'd3,  4'd13, 4'd4,  4'd7,  4'd15, 4'd2,  4'd8,  4'd14, 4'd12, 4'd0,  4'd1,  4'd10, 4'd6,  4'd9,  4'd11, 4'd5 },
      '{4'd0,  4'd14, 4'd7,  4'd11, 4'd10, 4'd4,  4'd13, 4'd1,  4'd5,  4'd8,  4'd12, 4'd6,  4'd9,  4'd3,  4'd2,  4'd15},
      '{4'd13, 4'd8,  4'd10, 4'd1,  4'd3,  4'd15, 4'd4,  4'd2,  4'd11, 4'd6,  4'd7,  4'd12, 4'd0,  4'd5,  4'd14, 4'd9 }
    },
    '{ // S3
      '{4'd10, 4'd0,  4'd9,  4'd14, 4'd6,  4'd3,  4'd15, 4'd5,  4'd1,  4'd13, 4'd12, 4'd7,  4'd11, 4'd4,  4'd2,  4'd8 },
      '{4'd13, 4'd7,  4'd0,  4'd9,  4'd3,  4'd4,  4'd6,  4'd10, 4'd2,  4'd8,  4'd5,  4'd14, 4'd12, 4'd11, 4'd15, 4'd1 },
      '{4'd13, 4'd6,  4'd4,  4'd9,  4'd8,  4'd15, 4'd3,  4'd0,  4'd11, 4'd1,  4'd2,  4'd12, 4'd5,  4'd10, 4'd14, 4'd7 },
      '{4'd1,  4'd10, 4'd13, 4'd0,  4'd6,  4'd9,  4'd8,  4'd7,  4'd4,  4'd15, 4'd14, 4'd3,  4'd11, 4'd5,  4'd2,  4'd12}
    },
    '{ // S4
      '{4'd7,  4'd13, 4'd14, 4'd3,  4'd0,  4'd6,  4'd9,  4'd10, 4'd1,  4'd2,  4'd8,  4'd5,  4'd11, 4'd12, 4'd4,  4'd15},
      '{4'd13, 4'd8,  4'd11, 4'd5,  4'd6,  4'd15, 4'd0,  4'd3,  4'd4,  4'd7,  4'd2,  4'd12, 4'd1,  4'd10, 4'd14, 4'd9 },
      '{4'd10, 4'd6,  4'd9,  4'd0,  4'd12, 4'd11, 4'd7,  4'd13, 4'd15, 4'd1,  4'd3,  4'd14, 4'd5,  4'd2,  4'd8,  4'd4 },
      '{4'd3,  4'd15, 4'd0,  4'd6,  4'd10, 4'd1,  4'd13, 4'd8,  4'd9,  4'd4,  4'd5,  4'd11, 4'd12, 4'd7,  4'd2,  4'd14}
    },
    '{ // S5
      '{4'd2,  4'd12, 4'd4,  4'd1,  4'd7,  4'd10, 4'd11, 4'd6,  4'd8,  4'd5,  4'd3,  4'd15, 4'd13, 4'd0,  4'd14, 4'd9 },
      '{4'd14, 4'd11, 4'd2,  4'd12, 4'd4,  4'd7,  4'd13, 4'd1,  4'd5,  4'd0,  4'd15, 4'd10, 4'd3,  4'd9,  4'd8,  4'd6 },
      '{4'd4,  4'd2,  4'd1,  4'd11, 4'd10, 4'd13, 4'd7,  4'd8,  4'd15, 4'd9,  4'd12, 4'd5,  4'd6,  4'd3,  4'd0,  4'd14},
      '{4'd11, 4'd8,  4'd12, 4'd7,  4'd1,  4'd14, 4'd2,  4'd13, 4'd6,  4'd15, 4'd0,  4'd9,  4'd10, 4'd4,  4'd5,  4'd3 }
    },
    '{ // S6
      '{4'd12, 4'd1,  4'd10, 4'd15, 4'd9,  4'd2,  4'd6,  4'd8,  4'd0,  4'd13, 4'd3,  4'd4,  4'd14, 4'd7,  4'd5,  4'd11},
      '{4'd10, 4'd15, 4'd4,  4'd2,  4'd7,  4'd12, 4'd9,  4'd5,  4'd6,  4'd1,  4'd13, 4'd14, 4'd0,  4'd11, 4'd3,  4'd8 },
      '{4'd9,  4'd14, 4'd15, 4'd5,  4'd2,  4'd8,  4'd12, 4'd3,  4'd7,  4'd0,  4'd4,  4'd10, 4'd1,  4'd13, 4'd11, 4'd6 },
      '{4'd4,  4'd3,  4'd2,  4'd12, 4'd9,  4'd5,  4'd15, 4'd10, 4'd11, 4'd14, 4'd1,  4'd7,  4'd6,  4'd0,  4'd8,  4'd13}
    },
    '{ // S7
      '{4'd4,  4'd11, 4'd2,  4'd14, 4'd15, 4'd0,  4'd8,  4'd13, 4'd3,  4'd12, 4'd9,  4'd7,  4'd5,  4'd10, 4'd6,  4'd1 },
      '{4'd13, 4'd0,  4'd11, 4'd7,  4'd4,  4'd9,  4'd1,  4'd10, 4'd14, 4'd3,  4'd5,  4'd12, 4'd2,  4'd15, 4'd8,  4'd6 },
      '{4'd1,  4'd4,  4'd11, 4'd13, 4'd12, 4'd3,  4'd7,  4'd14, 4'd10, 4'd15, 4'd6,  4'd8,  4'd0,  4'd5,  4'd9,  4'd2 },
      '{4'd6,  4'd11, 4'd13, 4'd8,  4'd1,  4'd4,  4'd10, 4'd7,  4'd9,  4'd5,  4'd0,  4'd15, 4'd14, 4'd2,  4'd3,  4'd12}
    },
    '{ // S8
      '{4'd13, 4'd2,  4'd8,  4'd4,  4'd6,  4'd15, 4'd11, 4'd1,  4'd10, 4'd9,  4'd3,  4'd14, 4'd5,  4'd0,  4'd12, 4'd7 },
      '{4'd1,  4'd15, 4'd13, 4'd8,  4'd10, 4'd3,  4'd7,  4'd4,  4'd12, 4'd5,  4'd6,  4'd11, 4'd0,  4'd14, 4'd9,  4'd2 },
      '{4'd7,  4'd11, 4'd4,  4'd1,  4'd9,  4'd12, 4'd14, 4'd2,  4'd0,  4'd6,  4'd10, 4'd13, 4'd15, 4'd3,  4'd5,  4'd8 },
      '{4'd2,  4'd1,  4'd14, 4'd7,  4'd4,  4'd10, 4'd8,  4'd13, 4'd15, 4'd12, 4'd9,  4'd0,  4'd3,  4'd5,  4'd6,  4'd11}
    }
  };

  // Row comes from the outer bits of the field, column from the inner four.
  function automatic logic [3:0] sbox_lookup(input logic [2:0] box, input logic [5:0] field);
    return SBOX[box][{field[5], field[0]}][field[4:1]];
  endfunction

endpackage

// File: rtl/des_sbox_lane.sv
// des_sbox_lane: one combinational S-box evaluation lane.
//   box      in  3  S-box select, 0..7 = S1..S8
//   field    in  6  6-bit input field for that box
//   sbox_out out 4  substituted nibble
module des_sbox_lane
  import des_sbox_pkg::*;
(
  input  logic [2:0] box,
  input  logic [5:0] field,
  output logic [3:0] sbox_out
);

  assign sbox_out = sbox_lookup(box, field);

endmodule

// File: rtl/des_sbox_engine.sv
// des_sbox_engine: DES S1..S8 substitution of a 48-bit keyed round word into
// a 32-bit word, evaluating LANES boxes per cycle behind valid/ready handshakes.
//   clk, rst            clock, asynchronous active-high reset
//   in_valid/in_ready   input handshake; in_data[47:42] = S1 field .. [5:0] = S8
//   out_valid/out_ready output handshake; out_data[31:28] = S1 .. [3:0] = S8
//   busy                high while substituting (CALC)
module des_sbox_engine
  import des_sbox_pkg::*;
#(
  parameter int LANES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [47:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        busy
);

  localparam int GROUPS = (LANES > 0) ? 8 / LANES : 1;
  localparam int GW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;

  if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8) begin : g_bad_lanes
    $error("des_sbox_engine: LANES must be 1, 2, 4 or 8");
  end

  state_t          state, nstate;
  logic [GW-1:0]   g;
  logic [47:0]     din_q;
  logic [31:0]     result;
  logic            last_group;
  logic            accept;
  logic [5:0]      field    [8];
  logic [2:0]      box_idx  [LANES];
  logic [3:0]      lane_out [LANES];
  logic [3:0]      box_nib  [8];
  logic            box_wr   [8];

  assign last_group = (g == GW'(GROUPS - 1));
  assign accept     = in_valid && in_ready;
  assign out_data   = result;

  for (genvar i = 0; i < 8; i++) begin : g_field
    assign field[i] = din_q[47 - 6*i -: 6];
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign box_idx[l] = 3'(g * LANES + l);
    des_sbox_lane u_lane (
      .box      (box_idx[l]),
      .field    (field[box_idx[l]]),
      .sbox_out (lane_out[l])
    );
  end

  // Box i is produced by lane i%LANES during group i/LANES; this static
  // mapping keeps the result write free of variable part-selects.
  for (genvar i = 0; i < 8; i++) begin : g_wr
    assign box_nib[i] = lane_out[i % LANES];
    assign box_wr[i]  = (state == CALC) && (g == GW'(i / LANES));
  end

  always_comb begin
    nstate    = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) nstate = CALC;
      end
      CALC: begin
        busy = 1'b1;
        if (last_group) nstate = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        // Accepting while the result is consumed skips the IDLE bubble.
        in_ready  = out_ready;
        if (out_ready) nstate = in_valid ? CALC : IDLE;
      end
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      g      <= '0;
      din_q  <= '0;
      result <= '0;
    end else begin
      state <= nstate;
      if (accept) din_q <= in_data;
      if (state == CALC) g <= last_group ? '0 : g + 1'b1;
      for (int unsigned i = 0; i < 8; i++)
        if (box_wr[i]) result[4*(7-i) +: 4] <= box_nib[i];
    end
  end

endmodule
